instr_fetch: RTL

Instruction fetch stage for the RISC machine. Holds the program counter, drives the read address of the synchronous-read RAM, and captures the returned word one cycle later. Presents instructions to decode through a valid/ready handshake. Absorbs the RAM's fixed 1-cycle read latency with a 2-entry return buffer, so decode stalls never lose an in-flight word. Supports branch redirect with flush.

---
 rtl/instr_fetch_if.sv | 46 ++++
 rtl/instr_fetch.sv | 115 +++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: the RAM read port plus the decode-side valid/ready
// handshake and the branch redirect request.
// The master side is the fetch stage; the slave side is the RAM/decode/branch
// environment around it.
interface instr_fetch_if #(
  parameter int data_width = 32,
  parameter int addr_width = 4
);

  // RAM read port
  logic [addr_width-1:0] mem_addr;
  logic [data_width-1:0] mem_data;

  // Branch redirect request
  logic                  redirect;
  logic [addr_width-1:0] redirect_pc;

  // Decode handshake
  logic                  instr_valid;
  logic                  instr_ready;
  logic [data_width-1:0] instr;
  logic [addr_width-1:0] instr_pc;

  modport master (
    output mem_addr,
    input  mem_data,
    input  redirect,
    input  redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc
  );

  modport slave (
    input  mem_addr,
    output mem_data,
    output redirect,
    output redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage.
// Holds the program counter and drives it straight onto the RAM read address.
// The RAM answers one cycle later, so every issued read is tracked as
// "in flight" for one cycle and then lands in a 2-entry return buffer.
// Decode pops the head of that buffer through a valid/ready handshake.
// A read is only issued when the buffer is guaranteed to have room for it.
// A redirect flushes the buffer and the in-flight read and restarts fetch.
module instr_fetch #(
  parameter int                    data_width = 32,
  parameter int                    addr_width = 4,
  parameter logic [addr_width-1:0] reset_pc   = '0
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);

  // Program counter and the read issued in the previous cycle
  logic [addr_width-1:0] pc;
  logic                  inflight_valid;
  logic [addr_width-1:0] inflight_pc;

  // Return buffer: slot 0 is always the head, slot 1 the entry behind it
  logic [data_width-1:0] slot_instr [2];
  logic [addr_width-1:0] slot_pc    [2];
  logic [1:0]            count;

  // Per-cycle control
  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] credit_used;

  // Handshake and credit decisions.
  // The credit counts buffered words plus the word already in flight, minus
  // the head leaving this cycle. Counting the same-cycle pop is what lets a
  // new read issue every cycle while decode keeps up. A redirect suppresses
  // both the issue and the push of the returning word.
  always_comb begin
    pop         = (count != 2'd0) && bus.instr_ready;
    push        = inflight_valid && !bus.redirect;
    credit_used = {1'b0, count} + {2'b00, inflight_valid} - {2'b00, pop};
    issue       = !bus.redirect && (credit_used < 3'd2);
  end

  // Program counter and in-flight tracking; redirect restarts fetch at the
  // branch target and drops the read that is currently in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= reset_pc;
      inflight_valid <= 1'b0;
      inflight_pc    <= '0;
    end else if (bus.redirect) begin
      pc             <= bus.redirect_pc;
      inflight_valid <= 1'b0;
    end else if (issue) begin
      pc             <= pc + addr_width'(1);
      inflight_valid <= 1'b1;
      inflight_pc    <= pc;
    end else begin
      inflight_valid <= 1'b0;
    end
  end

  // Return buffer: append the returning word, advance the head on a pop.
  // When both happen with one entry held, the new word becomes the head;
  // with two held, slot 1 moves up and the new word takes its place.
  // A redirect empties the buffer; a same-cycle pop has already handed the
  // head to decode, so nothing else needs undoing.
  always_ff @(posedge clk) begin
    if (reset) begin
      count         <= 2'd0;
      slot_instr[0] <= '0;
      slot_instr[1] <= '0;
      slot_pc[0]    <= '0;
      slot_pc[1]    <= '0;
    end else if (bus.redirect) begin
      count <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          slot_instr[count[0]] <= bus.mem_data;
          slot_pc[count[0]]    <= inflight_pc;
          count                <= count + 2'd1;
        end
        2'b01: begin
          slot_instr[0] <= slot_instr[1];
          slot_pc[0]    <= slot_pc[1];
          count         <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot_instr[0] <= bus.mem_data;
            slot_pc[0]    <= inflight_pc;
          end else begin
            slot_instr[0] <= slot_instr[1];
            slot_pc[0]    <= slot_pc[1];
            slot_instr[1] <= bus.mem_data;
            slot_pc[1]    <= inflight_pc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // All outputs come straight from registers; mem_data only reaches them
  // through the buffer.
  assign bus.mem_addr    = pc;
  assign bus.instr_valid = (count != 2'd0);
  assign bus.instr       = slot_instr[0];
  assign bus.instr_pc    = slot_pc[0];

endmodule
